alu32_seq: RTL

- Sequential ALU core that consumes the bitwise-logic slices (AND/OR/XOR/NOR) and adder results and registers the selected result.
- Adds a multi-cycle shift-add multiplier behind a start/done handshake.
- Sits between operand fetch and the result/writeback register.
- Single-cycle ops complete in one clock. MULT takes WIDTH clocks.

---
 rtl/alu32_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu32_seq.sv
// rtl/alu32_seq.sv - sequential ALU with registered result and shift-add multiplier
// Optional signed-overflow output enabled by defining ALU_OVERFLOW_EN.
module alu32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             zero
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_MULT = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_d;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    sum   = A + B;
    diff  = A - B;
    alu_d = '0;
    case (ALUop)
      OP_AND:  alu_d = A & B;
      OP_OR:   alu_d = A | B;
      OP_XOR:  alu_d = A ^ B;
      OP_NOR:  alu_d = ~(A | B);
      OP_ADD:  alu_d = sum;
      OP_SUB:  alu_d = diff;
      OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_d = '0;
    endcase
  end

  // One multiplier step: conditional add of the shifted multiplicand.
  always_comb begin
    acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_q;
  logic ovf_d;

  always_comb begin
    ovf_d = 1'b0;
    case (ALUop)
      OP_ADD:  ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1]  != A[WIDTH-1]);
      OP_SUB:  ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && start && ALUop != OP_MULT) begin
      ovf_q <= ovf_d;
    end else if (state_q == MUL && cnt_q == LAST_ITER) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      r_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (ALUop == OP_MULT) begin
              mcand_q  <= A;
              mplier_q <= B;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= MUL;
            end else begin
              r_q    <= alu_d;
              done_q <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // R is only written on the final iteration, so it holds the previous result meanwhile.
          if (cnt_q == LAST_ITER) begin
            r_q     <= acc_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign R    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign zero = (r_q == '0);

endmodule
